// File: rtl/core_pkg.sv
// Shared core-wide parameters and the writeback-select encoding.
package core_pkg;

  parameter int unsigned DATA_WIDTH     = 32;
  parameter int unsigned REG_ADDR_WIDTH = 5;

  // Writeback source select carried down the pipe from decode.
  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2
  } wb_sel_e;

endpackage

// File: rtl/wb_stage.sv
// Writeback stage: MEM/WB pipeline register, load-data alignment, writeback mux
// and the 64-bit retired-instruction counter. All outputs come from registered
// state only, so there is no input-to-output combinational path.
module wb_stage
  import core_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = core_pkg::DATA_WIDTH,
  parameter int unsigned REG_ADDR_WIDTH = core_pkg::REG_ADDR_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      stall_i,
  input  logic                      flush_i,
  input  logic                      MEM_valid_i,
  input  logic                      MEM_RegWrite_i,
  input  wb_sel_e                   MEM_WBSel_i,
  input  logic [REG_ADDR_WIDTH-1:0] MEM_rd_addr_i,
  input  logic [2:0]                MEM_funct3_i,
  input  logic [DATA_WIDTH-1:0]     MEM_alu_result_i,
  input  logic [DATA_WIDTH-1:0]     MEM_rd_data_i,
  input  logic [DATA_WIDTH-1:0]     MEM_pc_plus4_i,
  output logic                      WB_RegWrite_o,
  output logic [REG_ADDR_WIDTH-1:0] wr_addr_o,
  output logic [DATA_WIDTH-1:0]     wr_data_o,
  output logic                      misaligned_o,
  output logic [63:0]               instret_o
);

  // MEM/WB register fields
  logic                      r_valid;
  logic                      r_regwrite;
  wb_sel_e                   r_wbsel;
  logic [REG_ADDR_WIDTH-1:0] r_rd;
  logic [2:0]                r_funct3;
  logic [DATA_WIDTH-1:0]     r_alu_result;
  logic [DATA_WIDTH-1:0]     r_mem_data;
  logic [DATA_WIDTH-1:0]     r_pc_plus4;
  // Set only on the edge that loads a new entry, so a stalled entry retires once.
  logic                      r_fresh;
  logic [63:0]               r_instret;

  logic [1:0]            w_off;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [DATA_WIDTH-1:0] w_load_data;
  logic                  w_misaligned;
  logic [DATA_WIDTH-1:0] w_wr_data;
  logic                  w_retire;

  // Pipeline register: flush beats stall; stall holds everything but clears fresh.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid      <= 1'b0;
      r_regwrite   <= 1'b0;
      r_wbsel      <= WB_ALU;
      r_rd         <= '0;
      r_funct3     <= '0;
      r_alu_result <= '0;
      r_mem_data   <= '0;
      r_pc_plus4   <= '0;
      r_fresh      <= 1'b0;
    end else if (flush_i) begin
      r_valid    <= 1'b0;
      r_regwrite <= 1'b0;
      r_fresh    <= 1'b0;
    end else if (stall_i) begin
      r_fresh <= 1'b0;
    end else begin
      r_valid      <= MEM_valid_i;
      r_regwrite   <= MEM_RegWrite_i;
      r_wbsel      <= MEM_WBSel_i;
      r_rd         <= MEM_rd_addr_i;
      r_funct3     <= MEM_funct3_i;
      r_alu_result <= MEM_alu_result_i;
      r_mem_data   <= MEM_rd_data_i;
      r_pc_plus4   <= MEM_pc_plus4_i;
      r_fresh      <= 1'b1;
    end
  end

  assign w_off = r_alu_result[1:0];

  // Byte and halfword lane selection from the raw memory word.
  always_comb begin
    w_byte = r_mem_data[7:0];
    case (w_off)
      2'd1:    w_byte = r_mem_data[15:8];
      2'd2:    w_byte = r_mem_data[23:16];
      2'd3:    w_byte = r_mem_data[31:24];
      default: w_byte = r_mem_data[7:0];
    endcase
    w_half = w_off[1] ? r_mem_data[31:16] : r_mem_data[15:0];
  end

  // Size/sign extension by funct3; unknown encodings pass the whole word.
  always_comb begin
    w_load_data = r_mem_data;
    case (r_funct3)
      3'b000:  w_load_data = {{(DATA_WIDTH-8){w_byte[7]}}, w_byte};
      3'b100:  w_load_data = {{(DATA_WIDTH-8){1'b0}}, w_byte};
      3'b001:  w_load_data = {{(DATA_WIDTH-16){w_half[15]}}, w_half};
      3'b101:  w_load_data = {{(DATA_WIDTH-16){1'b0}}, w_half};
      default: w_load_data = r_mem_data;
    endcase
  end

  // Halfword loads need off[0]==0; word loads need off==0. Byte loads never fault.
  always_comb begin
    w_misaligned = 1'b0;
    if (r_valid && (r_wbsel == WB_MEM)) begin
      w_misaligned = ((r_funct3[1:0] == 2'b01) && w_off[0]) ||
                     ((r_funct3 == 3'b010) && (w_off != 2'd0));
    end
  end

  // Writeback source mux.
  always_comb begin
    w_wr_data = r_alu_result;
    case (r_wbsel)
      WB_ALU:  w_wr_data = r_alu_result;
      WB_MEM:  w_wr_data = w_load_data;
      WB_PC4:  w_wr_data = r_pc_plus4;
      default: w_wr_data = r_alu_result;
    endcase
  end

  assign w_retire = r_valid & r_fresh & ~w_misaligned;

  // Retired-instruction counter; wraps naturally at 2^64.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instret <= 64'd0;
    end else if (w_retire) begin
      r_instret <= r_instret + 64'd1;
    end
  end

  assign WB_RegWrite_o = r_valid & r_regwrite & (r_rd != '0) & ~w_misaligned;
  assign wr_addr_o     = r_rd;
  assign wr_data_o     = w_wr_data;
  assign misaligned_o  = w_misaligned;
  assign instret_o     = r_instret;

endmodule
